// File: rtl/uart_rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rom_loader_pkg
// Brief    : Shared loader state encoding and protocol constants.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rom_loader_pkg;

    localparam int DEFAULT_CLK_FREQ_HZ = 25125000;
    localparam int DEFAULT_BAUD_RATE   = 115200;
    localparam int HEADER_BYTES        = 2;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LDR_RESET = 4'd1,
        ST_CNT_HI    = 4'd2,
        ST_CNT_LO    = 4'd3,
        ST_WORD_HI   = 4'd4,
        ST_WORD_LO   = 4'd5,
        ST_LOAD      = 4'd6,
        ST_WAIT_ACK  = 4'd7,
        ST_DONE      = 4'd8,
        ST_ERROR     = 4'd9
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART receiver with input synchronizer and mid-bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 218
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       framing_error
);

    localparam int                 c_cnt_w     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_byte_valid;
    logic               r_framing_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_prev          <= 1'b1;
            r_state         <= c_rx_idle;
            r_cnt           <= '0;
            r_bit_idx       <= 3'd0;
            r_shift         <= 8'h00;
            r_byte_valid    <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_sync1         <= uart_rx;
            r_sync2         <= r_sync1;
            r_prev          <= r_sync2;
            r_byte_valid    <= 1'b0;
            r_framing_error <= 1'b0;
            case (r_state)
                c_rx_idle: begin
                    if (r_prev && !r_sync2) begin
                        r_state <= c_rx_start;
                        r_cnt   <= '0;
                    end
                end
                c_rx_start: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (r_cnt == c_half_last) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= r_sync2 ? c_rx_idle : c_rx_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_rx_data: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_rx_stop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_rx_stop: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt           <= '0;
                        r_state         <= c_rx_idle;
                        r_byte_valid    <= r_sync2;
                        r_framing_error <= !r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_rx_idle;
            endcase
        end
    end

    assign rx_byte       = r_shift;
    assign byte_valid    = r_byte_valid;
    assign framing_error = r_framing_error;

endmodule
`default_nettype wire

// File: rtl/uart_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_rom_loader
// Brief    : Receives a word-count-prefixed UART stream and feeds a ROM loader.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = DEFAULT_BAUD_RATE,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    input  logic                  run,
    output logic                  done_loading,
    output logic                  load_error,
    output logic                  rom_loader_reset,
    output logic                  rom_loader_load,
    output logic [DATA_WIDTH-1:0] rom_loader_data,
    input  logic                  rom_loader_load_received,
    input  logic                  rom_loader_ack
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_count_w    = HEADER_BYTES * 8;

    logic [7:0]            w_rx_byte;
    logic                  w_rx_valid;
    logic                  w_rx_fe;
    logic [7:0]            r_hold;
    logic                  r_hold_valid;
    logic                  w_byte_state;
    logic                  w_discard_state;
    logic                  w_consume;
    logic                  w_overrun;
    logic                  w_err_event;
    logic [c_count_w:0]    w_word_cnt_inc;
    logic                  w_last_word;

    loader_state_t         r_state;
    logic                  r_rst_cnt;
    logic [c_count_w-1:0]  r_count;
    logic [c_count_w-1:0]  r_word_cnt;
    logic [7:0]            r_word_hi;
    logic                  r_done;
    logic                  r_err;
    logic                  r_ldr_reset;
    logic                  r_load;
    logic [DATA_WIDTH-1:0] r_data;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .rx_byte       (w_rx_byte),
        .byte_valid    (w_rx_valid),
        .framing_error (w_rx_fe)
    );

    always_comb begin
        w_byte_state    = (r_state == ST_CNT_HI) || (r_state == ST_CNT_LO) ||
                          (r_state == ST_WORD_HI) || (r_state == ST_WORD_LO);
        w_discard_state = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
        w_consume       = r_hold_valid && (w_byte_state || w_discard_state);
        w_overrun       = w_rx_valid && r_hold_valid && !w_consume;
        w_err_event     = (w_rx_fe || w_overrun) && !w_discard_state;
        // Widened by one bit so N=65535 compares without wrapping.
        w_word_cnt_inc  = {1'b0, r_word_cnt} + 1'b1;
        w_last_word     = (w_word_cnt_inc == {1'b0, r_count});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
        end else if (w_rx_valid) begin
            r_hold       <= w_rx_byte;
            r_hold_valid <= 1'b1;
        end else if (w_consume) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rst_cnt   <= 1'b0;
            r_count     <= '0;
            r_word_cnt  <= '0;
            r_word_hi   <= 8'h00;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ldr_reset <= 1'b0;
            r_load      <= 1'b0;
            r_data      <= '0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ldr_reset <= 1'b0;
            r_load      <= 1'b0;
            if (!run && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
            end else if (w_err_event) begin
                r_state <= ST_ERROR;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (run) begin
                            r_state     <= ST_LDR_RESET;
                            r_ldr_reset <= 1'b1;
                            r_rst_cnt   <= 1'b0;
                            r_word_cnt  <= '0;
                        end
                    end
                    ST_LDR_RESET: begin
                        if (!r_rst_cnt) begin
                            r_rst_cnt   <= 1'b1;
                            r_ldr_reset <= 1'b1;
                        end else begin
                            r_state <= ST_CNT_HI;
                        end
                    end
                    ST_CNT_HI: begin
                        if (r_hold_valid) begin
                            r_count[15:8] <= r_hold;
                            r_state       <= ST_CNT_LO;
                        end
                    end
                    ST_CNT_LO: begin
                        if (r_hold_valid) begin
                            r_count[7:0] <= r_hold;
                            if ({r_count[15:8], r_hold} == 16'h0000) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_WORD_HI;
                            end
                        end
                    end
                    ST_WORD_HI: begin
                        if (r_hold_valid) begin
                            r_word_hi <= r_hold;
                            r_state   <= ST_WORD_LO;
                        end
                    end
                    ST_WORD_LO: begin
                        if (r_hold_valid) begin
                            r_data  <= DATA_WIDTH'({r_word_hi, r_hold});
                            r_state <= ST_LOAD;
                            r_load  <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (rom_loader_load_received) begin
                            r_state <= ST_WAIT_ACK;
                        end else begin
                            r_load <= 1'b1;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (rom_loader_ack) begin
                            r_word_cnt <= w_word_cnt_inc[c_count_w-1:0];
                            if (w_last_word) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_WORD_HI;
                            end
                        end
                    end
                    ST_DONE:  r_done <= 1'b1;
                    ST_ERROR: r_err  <= 1'b1;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign done_loading     = r_done;
    assign load_error       = r_err;
    assign rom_loader_reset = r_ldr_reset;
    assign rom_loader_load  = r_load;
    assign rom_loader_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rom_loader
// Brief    : Directed self-checking bench for uart_rom_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rom_loader;

    localparam int c_clks = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic        run;
    logic        done_loading;
    logic        load_error;
    logic        rom_loader_reset;
    logic        rom_loader_load;
    logic [15:0] rom_loader_data;
    logic        rom_loader_load_received;
    logic        rom_loader_ack;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_loads = 0;
    int          n_rst_cycles = 0;
    int          n_both = 0;
    logic        resp_en = 1'b1;
    logic [15:0] captured [0:7];

    uart_rom_loader #(
        .CLK_FREQ_HZ (1000000),
        .BAUD_RATE   (100000),
        .DATA_WIDTH  (16)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .uart_rx                  (uart_rx),
        .run                      (run),
        .done_loading             (done_loading),
        .load_error               (load_error),
        .rom_loader_reset         (rom_loader_reset),
        .rom_loader_load          (rom_loader_load),
        .rom_loader_data          (rom_loader_data),
        .rom_loader_load_received (rom_loader_load_received),
        .rom_loader_ack           (rom_loader_ack)
    );

    always #5 clk = ~clk;

    // Downstream model: capture, acknowledge receipt, ack 3 cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && rom_loader_load && !rom_loader_load_received) begin
                if (n_loads < 8) captured[n_loads] = rom_loader_data;
                n_loads++;
                rom_loader_load_received = 1'b1;
                @(negedge clk);
                rom_loader_load_received = 1'b0;
                repeat (2) @(negedge clk);
                rom_loader_ack = 1'b1;
                @(negedge clk);
                rom_loader_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rom_loader_reset) n_rst_cycles++;
            if (rom_loader_reset && rom_loader_load) n_both++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (c_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (c_clks) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (c_clks) @(negedge clk);
        uart_rx = 1'b1;
        repeat (c_clks) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !done_loading; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done_loading, load_error, rom_loader_reset, rom_loader_load} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000",
                     {done_loading, load_error, rom_loader_reset, rom_loader_load});
            n_errors++;
        end
        n_checks++;
        if (rom_loader_data !== 16'h0000) begin
            $display("FAIL reset_data: got %h expected 0000", rom_loader_data);
            n_errors++;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done_loading, load_error, rom_loader_reset, rom_loader_load} !== 4'b0000) begin
            $display("FAIL idle_after_reset: got %b expected 0000",
                     {done_loading, load_error, rom_loader_reset, rom_loader_load});
            n_errors++;
        end
    endtask

    task automatic run_two_words(input string name);
        n_loads = 0;
        n_rst_cycles = 0;
        n_both = 0;
        run = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        wait_done();
        n_checks++;
        if (done_loading !== 1'b1) begin
            $display("FAIL %s_done: got %b expected 1", name, done_loading);
            n_errors++;
        end
        n_checks++;
        if (n_loads != 2) begin
            $display("FAIL %s_load_count: got %0d expected 2", name, n_loads);
            n_errors++;
        end
        n_checks++;
        if (captured[0] !== 16'h1234) begin
            $display("FAIL %s_word0: got %h expected 1234", name, captured[0]);
            n_errors++;
        end
        n_checks++;
        if (captured[1] !== 16'hABCD) begin
            $display("FAIL %s_word1: got %h expected abcd", name, captured[1]);
            n_errors++;
        end
        n_checks++;
        if (n_rst_cycles != 2) begin
            $display("FAIL %s_reset_cycles: got %0d expected 2", name, n_rst_cycles);
            n_errors++;
        end
        n_checks++;
        if (n_both != 0 || load_error !== 1'b0) begin
            $display("FAIL %s_overlap_err: got %0d/%b expected 0/0", name, n_both, load_error);
            n_errors++;
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_loading !== 1'b0) begin
            $display("FAIL %s_done_clear: got %b expected 0", name, done_loading);
            n_errors++;
        end
    endtask

    task automatic test_two_words();
        run_two_words("two_words");
    endtask

    task automatic test_zero_words();
        n_loads = 0;
        run = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_done();
        n_checks++;
        if (done_loading !== 1'b1) begin
            $display("FAIL zero_done: got %b expected 1", done_loading);
            n_errors++;
        end
        n_checks++;
        if (n_loads != 0) begin
            $display("FAIL zero_loads: got %0d expected 0", n_loads);
            n_errors++;
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_framing();
        n_loads = 0;
        run = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (load_error !== 1'b1 || rom_loader_load !== 1'b0) begin
            $display("FAIL framing_err: got err=%b load=%b expected err=1 load=0",
                     load_error, rom_loader_load);
            n_errors++;
        end
        n_checks++;
        if (n_loads != 0) begin
            $display("FAIL framing_loads: got %0d expected 0", n_loads);
            n_errors++;
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (load_error !== 1'b0 || done_loading !== 1'b0) begin
            $display("FAIL framing_clear: got err=%b done=%b expected 0/0", load_error, done_loading);
            n_errors++;
        end
    endtask

    task automatic test_overrun();
        resp_en = 1'b0;
        run = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        for (int i = 0; i < 200 && !rom_loader_load; i++) @(negedge clk);
        n_checks++;
        if (rom_loader_load !== 1'b1 || rom_loader_data !== 16'h1122) begin
            $display("FAIL overrun_load: got load=%b data=%h expected 1/1122",
                     rom_loader_load, rom_loader_data);
            n_errors++;
        end
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        n_checks++;
        if (load_error !== 1'b1 || rom_loader_load !== 1'b0) begin
            $display("FAIL overrun_err: got err=%b load=%b expected err=1 load=0",
                     load_error, rom_loader_load);
            n_errors++;
        end
        run = 1'b0;
        resp_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        n_loads = 0;
        run = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        run = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done_loading, load_error, rom_loader_load} !== 3'b000 || n_loads != 0) begin
            $display("FAIL abort_idle: got %b loads=%0d expected 000 loads=0",
                     {done_loading, load_error, rom_loader_load}, n_loads);
            n_errors++;
        end
        repeat (5) @(negedge clk);
        run_two_words("rerun");
    endtask

    task automatic test_reset_mid_load();
        resp_en = 1'b0;
        run = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        for (int i = 0; i < 200 && !rom_loader_load; i++) @(negedge clk);
        n_checks++;
        if (rom_loader_load !== 1'b1 || rom_loader_data !== 16'hBEEF) begin
            $display("FAIL midreset_load: got load=%b data=%h expected 1/beef",
                     rom_loader_load, rom_loader_data);
            n_errors++;
        end
        reset = 1'b1;
        run = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done_loading, load_error, rom_loader_reset, rom_loader_load} !== 4'b0000 ||
            rom_loader_data !== 16'h0000) begin
            $display("FAIL midreset_outputs: got %b data=%h expected 0000 data=0000",
                     {done_loading, load_error, rom_loader_reset, rom_loader_load}, rom_loader_data);
            n_errors++;
        end
        reset = 1'b0;
        resp_en = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done_loading, load_error, rom_loader_reset, rom_loader_load} !== 4'b0000) begin
            $display("FAIL midreset_idle: got %b expected 0000",
                     {done_loading, load_error, rom_loader_reset, rom_loader_load});
            n_errors++;
        end
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        uart_rx = 1'b1;
        rom_loader_load_received = 1'b0;
        rom_loader_ack = 1'b0;
        for (int i = 0; i < 8; i++) captured[i] = 16'hxxxx;
        test_reset();
        test_two_words();
        test_zero_words();
        test_framing();
        test_overrun();
        test_abort();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rom_loader.md
UART_ROM_LOADER -- requirements
Module: uart_rom_loader

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 25125000, system clock frequency.
REQ-002 Parameter BAUD_RATE, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division).
REQ-003 Parameter DATA_WIDTH, default 16, ROM word width; fixed at 16 for this protocol.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 uart_rx  in  1  asynchronous serial input, 8N1, idle high.
REQ-007 run  in  1  level; high starts or continues a load session, low aborts it.
REQ-008 done_loading  out  1  high while in DONE.
REQ-009 load_error  out  1  high while in ERROR.
REQ-010 rom_loader_reset  out  1  resets the downstream ROM loader address counter.
REQ-011 rom_loader_load  out  1  word-valid strobe to the downstream ROM loader.
REQ-012 rom_loader_data  out  16  word to be written.
REQ-013 rom_loader_load_received  in  1  downstream has captured rom_loader_data.
REQ-014 rom_loader_ack  in  1  downstream write complete, ready for the next word.

Function
REQ-015 uart_rx passes through a 2-flop synchronizer before any use.
REQ-016 RX: start bit detected on the falling edge, confirmed low at mid-bit (CLKS_PER_BIT/2); 8 data bits LSB first, sampled at mid-bit; stop bit sampled at mid-bit; a low stop bit is a framing error.
REQ-017 Received bytes go to a 1-byte holding register with a valid flag; a new byte arriving while the flag is set is an overrun error.
REQ-018 Stream format: 2-byte word count N (MSB first), then N words, each sent MSB byte first.
REQ-019 FSM states: IDLE, LDR_RESET, CNT_HI, CNT_LO, WORD_HI, WORD_LO, LOAD, WAIT_ACK, DONE, ERROR.
REQ-020 IDLE: bytes discarded; run high -> LDR_RESET.
REQ-021 LDR_RESET: rom_loader_reset high for exactly 2 cycles, then CNT_HI.
REQ-022 CNT_HI/CNT_LO: consume one byte each into count[15:8]/count[7:0]; after CNT_LO, N=0 -> DONE, else WORD_HI.
REQ-023 WORD_HI/WORD_LO: consume one byte each into data[15:8]/data[7:0]; after WORD_LO -> LOAD.
REQ-024 LOAD: rom_loader_load high, rom_loader_data stable; stay until rom_loader_load_received high, then drop load the next cycle -> WAIT_ACK.
REQ-025 WAIT_ACK: on rom_loader_ack high, increment the 16-bit word counter; counter == N -> DONE, else WORD_HI.
REQ-026 Bytes arriving during LOAD/WAIT_ACK are held in the holding register (REQ-017), not lost.
REQ-027 DONE: done_loading high; stays until run low -> IDLE.
REQ-028 ERROR: entered on framing error or overrun in any state except IDLE/DONE; load_error high; rom_loader_load low; stays until run low -> IDLE.
REQ-029 run low in any non-IDLE state -> IDLE next cycle; rom_loader_load drops that same transition; a partial word is discarded.
REQ-030 rom_loader_load and rom_loader_reset are never high together.
REQ-031 Word counter and N are 16-bit unsigned; N=65535 is legal; no wrap-around before the compare.

Reset
REQ-032 On reset: FSM IDLE; done_loading, load_error, rom_loader_reset, rom_loader_load = 0; rom_loader_data = 16'h0000; counters, holding flag and RX state cleared; synchronizer flops = 1.
REQ-033 Reset mid-session takes priority over all events and returns to IDLE in one cycle.

Structure
REQ-034 Shared package holds the FSM state enum, the protocol constant HEADER_BYTES=2 and the default CLK_FREQ_HZ/BAUD_RATE values.
REQ-035 One sub-module, uart_rx_byte: synchronizer, bit timing, outputs byte, byte_valid (1-cycle pulse), framing_error (1-cycle pulse).

Verification
REQ-036 run=1, send 00 02 12 34 AB CD, downstream ack 3 cycles after load_received -> rom_loader_reset 2 cycles, loads 16'h1234 then 16'hABCD, done_loading=1.
REQ-037 run=1, send 00 00 -> done_loading=1 with no rom_loader_load pulse.
REQ-038 Header 00 01, word byte 55 sent with stop bit 0 -> load_error=1, no load; run=0 -> IDLE, error cleared.
REQ-039 Header 00 03; load_received held off for 3 byte-times during word 1 -> overrun, load_error=1, rom_loader_load=0.
REQ-040 Header 00 02, run dropped after 12 -> IDLE next cycle, no load issued; rerun with full stream completes normally.
REQ-041 reset pulsed while rom_loader_load=1 -> all outputs 0 the next cycle, FSM IDLE.
